// File: rtl/ias_mul_sequencer.sv
// ias_mul_sequencer
//   Iterative shift-add multiplier for the IAS ALU MUL instruction. It forms
//   the double-length product M(X) * MQ in the AC:MQ register pair, doing one
//   add-and-right-shift of the {carry, AC, MQ} chain per clock.
//
// Ports
//   clk     : clock, every state update happens on the rising edge
//   rst     : synchronous active-high reset
//   start   : multiply request, sampled only while not busy (IDLE or DONE)
//   mult    : multiplicand M(X), unsigned, captured on an accepted start
//   mq_in   : multiplier (MQ contents), unsigned, captured on an accepted start
//   busy    : high for the WIDTH iteration cycles
//   done    : one-cycle pulse, the product is valid on ac_out:mq_out
//   ac_out  : high half of the product (new AC)
//   mq_out  : low half of the product (new MQ)
module ias_mul_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] mult,
    input  logic [WIDTH-1:0] mq_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ac_out,
    output logic [WIDTH-1:0] mq_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] m_r;
    logic [WIDTH-1:0] ac_r;
    logic [WIDTH-1:0] mq_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sum;
    logic             last;

    // Partial-product add; the carry out becomes the top bit of the shifted AC.
    assign sum  = {1'b0, ac_r} + (mq_r[0] ? {1'b0, m_r} : '0);
    assign last = (cnt == CW'(WIDTH - 1));

    // Outputs come straight from registers or the state decode only.
    assign busy   = (state == S_RUN);
    assign done   = (state == S_DONE);
    assign ac_out = ac_r;
    assign mq_out = mq_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            m_r   <= '0;
            ac_r  <= '0;
            mq_r  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                // DONE accepts a new start exactly like IDLE, which gives the
                // one-product-per-(WIDTH+1)-cycles back-to-back rate.
                S_IDLE, S_DONE: begin
                    if (start) begin
                        m_r   <= mult;
                        mq_r  <= mq_in;
                        ac_r  <= '0;
                        cnt   <= '0;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // Right shift of {carry, AC, MQ}: the LSB of the sum drops
                    // into the MQ top while the consumed multiplier bit leaves.
                    ac_r <= sum[WIDTH:1];
                    mq_r <= {sum[0], mq_r[WIDTH-1:1]};
                    cnt  <= cnt + CW'(1);
                    if (last) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ias_mul_sequencer.sv
module tb_ias_mul_sequencer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] mult;
    logic [WIDTH-1:0] mq_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ac_out;
    logic [WIDTH-1:0] mq_out;

    int n_chk = 0;
    int n_err = 0;

    ias_mul_sequencer #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mult   (mult),
        .mq_in  (mq_in),
        .busy   (busy),
        .done   (done),
        .ac_out (ac_out),
        .mq_out (mq_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the product is just the exact arithmetic product.
    function automatic logic [31:0] ref_prod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] p;
        p = a * b;
        return 32'(p);
    endfunction

    // One start pulse, then follow the run: busy length, done result, hold.
    task automatic run_mul(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int busy_cnt = 0;
        bit got = 0;
        mult = a; mq_in = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mult = WIDTH'($urandom); mq_in = WIDTH'($urandom);
        for (int i = 0; i < 40 && !got; i++) begin
            if (done) got = 1;
            else begin
                if (busy) busy_cnt++;
                @(negedge clk);
            end
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_busy_len"}, busy_cnt, WIDTH);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, "_prod"}, {16'd0, ac_out, mq_out}, ref_prod(a, b));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_hold"}, {16'd0, ac_out, mq_out}, ref_prod(a, b));
    endtask

    initial begin
        int dcnt;
        int gap;
        bit got;
        logic [WIDTH-1:0] ra, rb;

        rst = 1'b1; start = 1'b0; mult = '0; mq_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ac", 32'(ac_out), 32'd0);
        chk("rst_mq", 32'(mq_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_mul("m13x11", 8'd13, 8'd11);
        chk("m13x11_lit", {16'd0, ac_out, mq_out}, 32'h008F);
        run_mul("mffxff", 8'hFF, 8'hFF);
        chk("mffxff_lit", {16'd0, ac_out, mq_out}, 32'hFE01);
        run_mul("m0xa5", 8'h00, 8'hA5);
        run_mul("m5ax0", 8'h5A, 8'h00);

        // start re-pulsed during RUN cycle 4 must be ignored
        mult = 8'd12; mq_in = 8'd10; start = 1'b1;
        @(negedge clk);          // RUN cycle 1
        start = 1'b0;
        repeat (3) @(negedge clk); // RUN cycle 4
        mult = 8'd3; mq_in = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0; got = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                dcnt++;
                if (!got) chk("ign_prod", {16'd0, ac_out, mq_out}, 32'h0078);
                got = 1;
            end
            @(negedge clk);
        end
        chk("ign_done_cnt", dcnt, 1);

        // start held high: 7*9, then 200*2 presented in the DONE cycle
        mult = 8'd7; mq_in = 8'd9; start = 1'b1;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        chk("held1_seen", 32'(got), 32'd1);
        chk("held1_prod", {16'd0, ac_out, mq_out}, 32'h003F);
        mult = 8'd200; mq_in = 8'd2;
        gap = 0; got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            gap++;
            if (done) got = 1;
        end
        start = 1'b0;
        chk("held2_seen", 32'(got), 32'd1);
        chk("held_gap", gap, WIDTH + 1);
        chk("held2_prod", {16'd0, ac_out, mq_out}, 32'h0190);
        @(negedge clk);
        chk("held_idle", {30'd0, busy, done}, 32'd0);

        // reset mid-RUN discards the product
        mult = 8'd77; mq_in = 8'd99; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk); // RUN cycle 5
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_acmq", {16'd0, ac_out, mq_out}, 32'd0);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        chk("mrst_no_done", dcnt, 0);
        run_mul("after_rst", 8'd77, 8'd99);

        for (int t = 0; t < 20; t++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            run_mul("rand", ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
